// File: rtl/alu_req_sequencer.sv
// Request/response sequencer that drives the ALU operand pins for one operation at a time,
// waits the command-dependent latency, captures the ALU result and hands it back.
module alu_req_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int ALU_LAT   = 1,
    parameter int MUL_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // request side
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_mode,
    input  logic [CMD_WIDTH-1:0]   req_cmd,
    input  logic                   req_cin,
    input  logic [1:0]             req_inp_valid,
    input  logic [WIDTH-1:0]       req_opa,
    input  logic [WIDTH-1:0]       req_opb,
    // response side
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_res,
    output logic                   rsp_cout,
    output logic                   rsp_oflow,
    output logic                   rsp_g,
    output logic                   rsp_l,
    output logic                   rsp_e,
    output logic                   rsp_err,
    output logic [15:0]            op_count,
    // ALU pins
    output logic                   CE,
    output logic [1:0]             INP_VALID,
    output logic                   MODE,
    output logic [CMD_WIDTH-1:0]   CMD,
    output logic                   CIN,
    output logic [WIDTH-1:0]       OPA,
    output logic [WIDTH-1:0]       OPB,
    input  logic [2*WIDTH-1:0]     RES,
    input  logic                   COUT,
    input  logic                   OFLOW,
    input  logic                   G,
    input  logic                   L,
    input  logic                   E,
    input  logic                   ERR,
    // FSM state for observation: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP
    output logic [1:0]             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge, and ready may not
    // depend on the request contents.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CNT_W = 8;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   lat_cnt_q;
    logic [1:0]         iv_q;
    logic               rsp_valid_q;

    logic               req_fire;
    logic               req_empty;
    logic               req_is_mul;
    logic [CNT_W-1:0]   lat_load;
    logic               capture;
    logic               rsp_fire;
    logic               alu_active;

    assign req_fire   = (state_q == S_IDLE) && req_valid;
    assign req_empty  = (req_inp_valid == 2'b00);
    assign req_is_mul = req_mode && ((req_cmd == CMD_WIDTH'(9)) || (req_cmd == CMD_WIDTH'(10)));
    assign lat_load   = req_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
    // Last WAIT cycle: the counter would reach zero on this edge.
    assign capture    = (state_q == S_WAIT) && (lat_cnt_q <= CNT_W'(1));
    assign rsp_fire   = (state_q == S_RESP) && rsp_valid_q && rsp_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = req_empty ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        alu_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
        req_ready  = (state_q == S_IDLE) && rst_n;
        CE         = alu_active;
        INP_VALID  = alu_active ? iv_q : 2'b00;
        rsp_valid  = rsp_valid_q;
        dbg_state  = state_q;
    end

    // ALU pin registers only change on a real (non-empty) request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MODE      <= 1'b0;
            CMD       <= '0;
            CIN       <= 1'b0;
            OPA       <= '0;
            OPB       <= '0;
            iv_q      <= 2'b00;
            lat_cnt_q <= '0;
        end else if (req_fire && !req_empty) begin
            MODE      <= req_mode;
            CMD       <= req_cmd;
            CIN       <= req_cin;
            OPA       <= req_opa;
            OPB       <= req_opb;
            iv_q      <= req_inp_valid;
            lat_cnt_q <= lat_load;
        end else if ((state_q == S_WAIT) && !capture) begin
            lat_cnt_q <= lat_cnt_q - CNT_W'(1);
        end
    end

    // Response registers. An empty request enters RESP with valid still low so that the
    // error response appears one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_res     <= '0;
            rsp_cout    <= 1'b0;
            rsp_oflow   <= 1'b0;
            rsp_g       <= 1'b0;
            rsp_l       <= 1'b0;
            rsp_e       <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (req_fire && req_empty) begin
                rsp_res   <= '0;
                rsp_cout  <= 1'b0;
                rsp_oflow <= 1'b0;
                rsp_g     <= 1'b0;
                rsp_l     <= 1'b0;
                rsp_e     <= 1'b0;
                rsp_err   <= 1'b1;
            end
            if (capture) begin
                rsp_res     <= RES;
                rsp_cout    <= COUT;
                rsp_oflow   <= OFLOW;
                rsp_g       <= G;
                rsp_l       <= L;
                rsp_e       <= E;
                rsp_err     <= ERR;
                rsp_valid_q <= 1'b1;
            end
            if ((state_q == S_RESP) && !rsp_valid_q) begin
                rsp_valid_q <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 16'h0000;
        end else if (rsp_fire) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
